// File: rtl/ramio_arbiter_pkg.sv
// Shared types and helpers for the two-requester ramio arbiter.
package ramio_arbiter_pkg;

  localparam int ReadTypeW  = 3;
  localparam int WriteTypeW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // A write finishes when ramio is not busy; a read also needs its data ready.
  function automatic logic xfer_complete(input logic                 busy,
                                         input logic                 ready,
                                         input logic [ReadTypeW-1:0] read_type);
    return !busy && ((read_type == '0) || ready);
  endfunction

endpackage

// File: rtl/ramio_arbiter_if.sv
// Requester-side link (core -> arbiter) and the shared ramio client port.
interface ramio_arbiter_if #(
  parameter int AddressBitWidth = 32,
  parameter int DataBitWidth    = 32
);
  logic                                   enable;
  logic [ramio_arbiter_pkg::ReadTypeW-1:0]  read_type;
  logic [ramio_arbiter_pkg::WriteTypeW-1:0] write_type;
  logic [AddressBitWidth-1:0]             address;
  logic [DataBitWidth-1:0]                data_in;
  logic [DataBitWidth-1:0]                data_out;
  logic                                   done;

  modport master (output enable, read_type, write_type, address, data_in,
                  input  data_out, done);
  modport slave  (input  enable, read_type, write_type, address, data_in,
                  output data_out, done);
endinterface

interface ramio_port_if #(
  parameter int AddressBitWidth = 32,
  parameter int DataBitWidth    = 32
);
  logic                                   enable;
  logic [ramio_arbiter_pkg::ReadTypeW-1:0]  read_type;
  logic [ramio_arbiter_pkg::WriteTypeW-1:0] write_type;
  logic [AddressBitWidth-1:0]             address;
  logic [DataBitWidth-1:0]                data_in;
  logic [DataBitWidth-1:0]                data_out;
  logic                                   data_out_ready;
  logic                                   busy;

  modport master (output enable, read_type, write_type, address, data_in,
                  input  data_out, data_out_ready, busy);
  modport slave  (input  enable, read_type, write_type, address, data_in,
                  output data_out, data_out_ready, busy);
endinterface

// File: rtl/ramio_arbiter.sv
// Round-robin arbiter sharing one ramio client port between instruction fetch
// (m0) and load/store (m1); each grant is held until completion or timeout.
module ramio_arbiter
  import ramio_arbiter_pkg::*;
#(
  parameter int AddressBitWidth = 32,
  parameter int DataBitWidth    = 32,
  parameter int TimeoutCycles   = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  ramio_arbiter_if.slave  m0,
  ramio_arbiter_if.slave  m1,
  ramio_port_if.master    r,
  output logic            timeout_err
);

  localparam int                TcntW    = $clog2(TimeoutCycles);
  localparam logic [TcntW-1:0]  TcntLast = TcntW'(TimeoutCycles - 1);

  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("ramio_arbiter: TimeoutCycles must be at least 2");
  end

  arb_state_e                 state, state_nxt;
  logic                       last, last_nxt;
  logic [TcntW-1:0]           tcnt, tcnt_nxt;
  logic                       timeout_err_nxt;

  logic                       granted, sel1;
  logic                       complete, abort, finish;
  logic [ReadTypeW-1:0]       cmd_rt;
  logic [WriteTypeW-1:0]      cmd_wt;
  logic [AddressBitWidth-1:0] cmd_addr;
  logic [DataBitWidth-1:0]    cmd_wdata;

  // Downstream command mux; everything stays zero outside a grant because
  // ramio I/O side effects decode address/type without looking at enable.
  always_comb begin
    granted   = (state == GNT0) || (state == GNT1);
    sel1      = (state == GNT1);
    cmd_rt    = '0;
    cmd_wt    = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    if (state == GNT0) begin
      cmd_rt    = m0.read_type;
      cmd_wt    = m0.write_type;
      cmd_addr  = m0.address;
      cmd_wdata = m0.data_in;
    end else if (state == GNT1) begin
      cmd_rt    = m1.read_type;
      cmd_wt    = m1.write_type;
      cmd_addr  = m1.address;
      cmd_wdata = m1.data_in;
    end
    complete = granted && xfer_complete(r.busy, r.data_out_ready, cmd_rt);
    abort    = granted && !complete && (tcnt == TcntLast);
    finish   = complete || abort;
  end

  assign r.enable     = granted;
  assign r.read_type  = cmd_rt;
  assign r.write_type = cmd_wt;
  assign r.address    = cmd_addr;
  assign r.data_in    = cmd_wdata;

  assign m0.done      = finish && !sel1;
  assign m1.done      = finish && sel1;
  assign m0.data_out  = (complete && !sel1) ? r.data_out : '0;
  assign m1.data_out  = (complete && sel1)  ? r.data_out : '0;

  // Grants only start from IDLE, so every grant is followed by an idle cycle.
  always_comb begin
    state_nxt       = state;
    last_nxt        = last;
    tcnt_nxt        = tcnt;
    timeout_err_nxt = timeout_err | abort;
    unique case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (m0.enable && (!m1.enable || last)) begin
          state_nxt = GNT0;
          last_nxt  = 1'b0;
        end else if (m1.enable) begin
          state_nxt = GNT1;
          last_nxt  = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (finish) begin
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      tcnt        <= tcnt_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_ramio_arbiter.sv
// Self-checking bench: two arbiters (default and short timeout) against a
// transaction-level ownership model, plus directed literal checks.
module tb_ramio_arbiter;

  localparam logic [31:0] TopAddress = 32'h0001_0000;

  typedef struct packed {
    logic [2:0]  rt;
    logic [1:0]  wt;
    logic [31:0] addr;
    logic [31:0] wd;
  } cmd_t;

  typedef struct packed {
    logic        en;
    logic [2:0]  rt;
    logic [1:0]  wt;
    logic [31:0] ad;
    logic [31:0] wd;
  } bus_t;

  logic clk = 1'b0;
  logic rst_n;
  logic terr0, terr1;
  always #5 clk = ~clk;

  // requester index k: 0,1 -> dut (m0,m1); 2,3 -> dut_t (m0,m1)
  logic        req [4];
  cmd_t        cmd [4];
  cmd_t        pq  [4][$];
  int          mem_lat [2];
  logic [31:0] mem_rdata [2];
  int          mem_cnt [2];
  int          uart_hits = 0;
  logic [7:0]  uart_last = 8'h00;
  int          tmo [2] = '{1024, 8};

  ramio_arbiter_if a0 (), a1 (), a2 (), a3 ();
  ramio_port_if    p0 (), p1 ();

  ramio_arbiter #(.AddressBitWidth(32), .DataBitWidth(32), .TimeoutCycles(1024)) dut (
    .clk(clk), .rst_n(rst_n), .m0(a0), .m1(a1), .r(p0), .timeout_err(terr0));
  ramio_arbiter #(.AddressBitWidth(32), .DataBitWidth(32), .TimeoutCycles(8)) dut_t (
    .clk(clk), .rst_n(rst_n), .m0(a2), .m1(a3), .r(p1), .timeout_err(terr1));

  assign a0.enable = req[0]; assign a0.read_type = cmd[0].rt; assign a0.write_type = cmd[0].wt;
  assign a0.address = cmd[0].addr; assign a0.data_in = cmd[0].wd;
  assign a1.enable = req[1]; assign a1.read_type = cmd[1].rt; assign a1.write_type = cmd[1].wt;
  assign a1.address = cmd[1].addr; assign a1.data_in = cmd[1].wd;
  assign a2.enable = req[2]; assign a2.read_type = cmd[2].rt; assign a2.write_type = cmd[2].wt;
  assign a2.address = cmd[2].addr; assign a2.data_in = cmd[2].wd;
  assign a3.enable = req[3]; assign a3.read_type = cmd[3].rt; assign a3.write_type = cmd[3].wt;
  assign a3.address = cmd[3].addr; assign a3.data_in = cmd[3].wd;

  // ramio stand-in: busy for mem_lat cycles of a grant, then ready for reads
  assign p0.busy           = p0.enable && (mem_cnt[0] < mem_lat[0]);
  assign p0.data_out_ready = p0.enable && (p0.read_type != 3'd0) && !p0.busy;
  assign p0.data_out       = p0.data_out_ready ? mem_rdata[0] : 32'h0;
  assign p1.busy           = p1.enable && (mem_cnt[1] < mem_lat[1]);
  assign p1.data_out_ready = p1.enable && (p1.read_type != 3'd0) && !p1.busy;
  assign p1.data_out       = p1.data_out_ready ? mem_rdata[1] : 32'h0;

  // UART out decodes address/write_type without enable, like ramio does
  always @(posedge clk) begin
    mem_cnt[0] <= p0.enable ? mem_cnt[0] + 1 : 0;
    mem_cnt[1] <= p1.enable ? mem_cnt[1] + 1 : 0;
    if (p0.write_type != 2'd0 && p0.address == TopAddress - 1) begin
      uart_hits <= uart_hits + 1;
      uart_last <= p0.data_in[7:0];
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bus_t        s_bus [2];
  logic        s_done [4];
  logic [31:0] s_dout [4];
  logic        s_terr [2];
  logic        s_busy [2];
  logic        s_rdy  [2];
  logic [31:0] s_rdata [2];
  int          dlog [$];
  int          dcyc [$];

  // model: who owns the port (-1 none), who wins the next tie, grant age
  int          m_own [2]  = '{-1, -1};
  int          m_tie [2]  = '{0, 0};
  int          m_age [2]  = '{0, 0};
  bit          m_err [2]  = '{0, 0};
  bit          m_known [2] = '{0, 0};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic compare(input int d);
    int          kb  = 2 * d;
    int          own = m_own[d];
    bus_t        eb  = '0;
    logic [1:0]  ed  = 2'b00;
    logic [31:0] eo0 = 32'h0;
    logic [31:0] eo1 = 32'h0;
    logic        ok  = 1'b0;
    logic        to  = 1'b0;
    if (own >= 0) begin
      eb = {1'b1, cmd[kb+own]};
      ok = !s_busy[d] && (cmd[kb+own].rt == 3'd0 || s_rdy[d]);
      to = !ok && (m_age[d] == tmo[d] - 1);
      ed[own] = ok || to;
      if (own == 0) eo0 = ok ? s_rdata[d] : 32'h0;
      else          eo1 = ok ? s_rdata[d] : 32'h0;
    end
    if (m_known[d]) begin
      chk($sformatf("d%0d_r_bus", d), s_bus[d], eb);
      chk($sformatf("d%0d_done", d), {s_done[kb+1], s_done[kb]}, ed);
      chk($sformatf("d%0d_m0_data_out", d), s_dout[kb], eo0);
      chk($sformatf("d%0d_m1_data_out", d), s_dout[kb+1], eo1);
      chk($sformatf("d%0d_timeout_err", d), s_terr[d], m_err[d]);
    end
    if (!rst_n) begin
      m_own[d] = -1; m_tie[d] = 0; m_age[d] = 0; m_err[d] = 0; m_known[d] = 1;
    end else if (m_known[d]) begin
      if (own >= 0) begin
        if (ed[own]) begin
          m_own[d] = -1;
          if (to) m_err[d] = 1;
        end else begin
          m_age[d]++;
        end
      end else begin
        if (req[kb] && req[kb+1]) m_own[d] = m_tie[d];
        else if (req[kb])         m_own[d] = 0;
        else if (req[kb+1])       m_own[d] = 1;
        if (m_own[d] >= 0) begin
          m_tie[d] = 1 - m_own[d];
          m_age[d] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    s_bus[0] = {p0.enable, p0.read_type, p0.write_type, p0.address, p0.data_in};
    s_bus[1] = {p1.enable, p1.read_type, p1.write_type, p1.address, p1.data_in};
    s_done[0] = a0.done; s_done[1] = a1.done; s_done[2] = a2.done; s_done[3] = a3.done;
    s_dout[0] = a0.data_out; s_dout[1] = a1.data_out;
    s_dout[2] = a2.data_out; s_dout[3] = a3.data_out;
    s_terr[0] = terr0; s_terr[1] = terr1;
    s_busy[0] = p0.busy; s_busy[1] = p1.busy;
    s_rdy[0] = p0.data_out_ready; s_rdy[1] = p1.data_out_ready;
    s_rdata[0] = p0.data_out; s_rdata[1] = p1.data_out;
    compare(0);
    compare(1);
    for (int k = 0; k < 4; k++) begin
      if (s_done[k] === 1'b1) begin
        dlog.push_back(k);
        dcyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (s_done[k] === 1'b1) begin
        if (pq[k].size() > 0) cmd[k] = pq[k].pop_front();
        else                  req[k] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int k, input cmd_t c);
    if (!req[k]) begin
      cmd[k] = c;
      req[k] = 1'b1;
    end else begin
      pq[k].push_back(c);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req[k] = 1'b0;
      pq[k].delete();
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int k, input int bound, output int gcyc, output logic [31:0] data);
    int d = k / 2;
    gcyc = 0;
    data = 32'h0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (s_bus[d].en) gcyc++;
      if (s_done[k] === 1'b1) begin
        data = s_dout[k];
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_done_%0d: no done within %0d cycles", k, bound);
  endtask

  function automatic cmd_t mk(input logic [2:0] rt, input logic [1:0] wt,
                              input logic [31:0] a, input logic [31:0] w);
    return {rt, wt, a, w};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g;
    int          n;
    int          bad;
    int          early;
    int          hits0;
    logic [31:0] data;
    logic [7:0]  ord;
    bit          seen0;

    for (int k = 0; k < 4; k++) begin
      req[k] = 1'b0;
      cmd[k] = '0;
    end
    mem_lat   = '{0, 0};
    mem_rdata = '{32'h0, 32'h0};
    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_r_bus_%0d", d), s_bus[d], 0);
      chk($sformatf("reset_done_%0d", d), {s_done[2*d+1], s_done[2*d]}, 0);
      chk($sformatf("reset_timeout_err_%0d", d), s_terr[d], 0);
    end

    // single read by requester 0: busy 3 cycles, data in grant cycle 4
    mem_lat[0]   = 3;
    mem_rdata[0] = 32'hDEAD_BEEF;
    issue(0, mk(3'd2, 2'd0, 32'h100, 32'h0));
    wait_done(0, 20, g, data);
    chk("t1_grant_cycles", g, 4);
    chk("t1_data", data, 32'hDEAD_BEEF);
    tick();
    chk("t1_idle_bus", s_bus[0], 0);
    n = dlog.size();
    tick();
    tick();
    chk("t1_single_pulse", dlog.size(), n);

    // contention from reset: 4 writes each, strictly alternating 0,1,0,1...
    do_reset();
    mem_lat[0] = 0;
    dlog.delete();
    dcyc.delete();
    for (int i = 0; i < 4; i++) begin
      issue(0, mk(3'd0, 2'd3, 32'h10 + 32'(8 * i), 32'h1000 + 32'(i)));
      issue(1, mk(3'd0, 2'd3, 32'h14 + 32'(8 * i), 32'h2000 + 32'(i)));
    end
    for (int i = 0; i < 40 && dlog.size() < 8; i++) tick();
    if (dlog.size() < 8) begin
      n_tests++;
      n_fail++;
      $display("FAIL t2_wait: only %0d of 8 done pulses", dlog.size());
    end
    ord = 8'h00;
    for (int i = 0; i < 8 && i < dlog.size(); i++) ord[i] = (dlog[i] == 1);
    chk("t2_grant_order", ord, 8'hAA);
    for (int i = 1; i < 8 && i < dcyc.size(); i++)
      chk($sformatf("t2_spacing_%0d", i), dcyc[i] - dcyc[i-1], 2);

    // requester 1 stores 0x41 to UART out while requester 0 is quiet
    tick();
    hits0 = uart_hits;
    bad = 0;
    n = 0;
    issue(1, mk(3'd0, 2'd1, TopAddress - 1, 32'h0000_0041));
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_bus[0].ad == TopAddress - 1) bad++;
      if (s_done[1] === 1'b1) n++;
    end
    chk("t3_addr_cycles", bad, 1);
    chk("t3_done_count", n, 1);
    chk("t3_uart_hits", uart_hits - hits0, 1);
    chk("t3_uart_byte", uart_last, 8'h41);

    // requester 0 holds a slow read while requester 1 keeps asking
    mem_lat[0]   = 10;
    mem_rdata[0] = 32'hCAFE_0000;
    issue(0, mk(3'd2, 2'd0, 32'h200, 32'h0));
    tick();
    issue(1, mk(3'd2, 2'd0, 32'h300, 32'h0));
    g = 0; bad = 0; early = 0; seen0 = 0; data = 32'h0;
    for (int i = 0; i < 30 && !seen0; i++) begin
      tick();
      if (s_bus[0].en) begin
        g++;
        if (s_bus[0].ad != 32'h200) bad++;
      end
      if (s_done[1] === 1'b1) early++;
      if (s_done[0] === 1'b1) begin
        seen0 = 1;
        data  = s_dout[0];
      end
    end
    chk("t4_m0_grant_cycles", g, 11);
    chk("t4_addr_held", bad, 0);
    chk("t4_m1_not_early", early, 0);
    chk("t4_m0_data", data, 32'hCAFE_0000);
    wait_done(1, 40, g, data);
    chk("t4_m1_data", data, 32'hCAFE_0000);

    // short-timeout arbiter: busy stuck, abort after 8 granted cycles
    tick();
    mem_lat[1] = 1000;
    issue(2, mk(3'd2, 2'd0, 32'h400, 32'h0));
    wait_done(2, 30, g, data);
    chk("t5_abort_cycles", g, 8);
    chk("t5_abort_data", data, 32'h0);
    tick();
    chk("t5_timeout_err_set", s_terr[1], 1'b1);
    mem_lat[1]   = 0;
    mem_rdata[1] = 32'h5A5A_5A5A;
    issue(2, mk(3'd2, 2'd0, 32'h404, 32'h0));
    wait_done(2, 10, g, data);
    chk("t5_recover_data", data, 32'h5A5A_5A5A);
    tick();
    chk("t5_timeout_err_sticky", s_terr[1], 1'b1);
    chk("t5_other_err_clear", s_terr[0], 1'b0);

    // reset in the middle of a grant
    mem_lat[1] = 1000;
    issue(2, mk(3'd2, 2'd0, 32'h408, 32'h0));
    n = dlog.size();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    req[2] = 1'b0;
    tick();
    chk("t6_no_done", dlog.size(), n);
    chk("t6_bus_idle", s_bus[1], 0);
    chk("t6_data_zero", s_dout[2], 0);
    chk("t6_timeout_err_cleared", s_terr[1], 1'b0);
    mem_lat[1]   = 0;
    mem_rdata[1] = 32'h1357_9BDF;
    issue(2, mk(3'd2, 2'd0, 32'h408, 32'h0));
    wait_done(2, 10, g, data);
    chk("t6_reissue_data", data, 32'h1357_9BDF);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ramio_arbiter.md
# ramio_arbiter

Two-requester arbiter in front of `ramio`. It shares the single `ramio` client port between requester 0 (instruction fetch) and requester 1 (load/store). Grants are round-robin, and a grant is held until the `ramio` transaction completes. While no requester is granted, the downstream port is driven fully idle (all zeros); this matters because `ramio` UART/LED side effects decode `address`/`read_type`/`write_type` without qualification by `enable`.

## Interface
- `AddressBitWidth`, 32: address width, both sides.
- `DataBitWidth`, 32: data width, both sides.
- `TimeoutCycles`, 1024: maximum cycles one grant may last before abort; must be ≥ 2.
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `m0_enable`, `m1_enable` input 1: request; held stable with its command until that requester's `done`.
- `m0_read_type`, `m1_read_type` input 3: same encoding as `ramio` `read_type`.
- `m0_write_type`, `m1_write_type` input 2: same encoding as `ramio` `write_type`.
- `m0_address`, `m1_address` input AddressBitWidth: byte address.
- `m0_data_in`, `m1_data_in` input DataBitWidth: write data.
- `m0_data_out`, `m1_data_out` output DataBitWidth: read data; valid only while that requester's `done` is high, else 0.
- `m0_done`, `m1_done` output 1: one-cycle completion pulse.
- `r_enable`, `r_read_type`, `r_write_type`, `r_address`, `r_data_in` output: to `ramio`.
- `r_data_out` input DataBitWidth: from `ramio`.
- `r_data_out_ready` input 1: from `ramio`.
- `r_busy` input 1: from `ramio`.
- `timeout_err` output 1: sticky; set on any aborted grant.

## Operation
- States:
  - IDLE: no grant.
  - GNT0: requester 0 granted.
  - GNT1: requester 1 granted.
- Register `last` records the requester most recently granted. Reset value 1, so requester 0 wins the first tie.
- IDLE transitions:
  - Only one `mN_enable` high: go to GNTN.
  - Both high: grant the requester that is not `last`.
  - Neither high: stay in IDLE.
  - On every grant, update `last`.
- In GNTN, downstream `r_*` equals requester N's command, with `r_enable` = 1. In IDLE, all `r_*` outputs are 0.
- Completion, evaluated in GNTN: `r_busy == 0` and (`r_read_type == 0` or `r_data_out_ready == 1`).
- On completion:
  - `mN_done` = 1 in that cycle (combinational).
  - `mN_data_out` = `r_data_out`.
  - Next state is IDLE.
- Every grant is followed by at least one IDLE cycle. This guarantees `ramio` sees the address change, and an I/O access (UART in/out, LED) is presented for exactly one cycle. I/O accesses complete in their first granted cycle because `ramio` reports busy = 0 and ready = 1 for them.
- Timeout:
  - Counter `tcnt` clears on entry to GNTN and increments each granted cycle without completion.
  - When `tcnt == TimeoutCycles-1` without completion: abort, pulse `mN_done` with `mN_data_out` = 0, set `timeout_err`, go to IDLE.
- Dropping `mN_enable` during a grant is illegal. The arbiter ignores it and keeps the grant until completion or timeout.

## Timing
- Reset values:
  - state IDLE, `last` = 1, `tcnt` = 0, `timeout_err` = 0.
  - All `r_*` outputs 0; all `mN_done` and `mN_data_out` 0.
- Request-to-grant latency: `enable` sampled high in IDLE at edge k drives `r_enable` = 1 from cycle k+1.
- Minimum transaction (cache hit or I/O): granted at k+1, `done` at k+1, IDLE at k+2. Maximum throughput is one transaction per 2 cycles.
- Back-to-back under contention: requester 0 at k+1 and requester 1 at k+3, strictly alternating.
- Simultaneous completion and new request: the new request is sampled in the following IDLE cycle and is not granted in the completion cycle.
- Reset asserted mid-grant: next cycle is IDLE with outputs at reset values. The in-flight transaction produces no `done`; the requester reissues it.
- `tcnt` width is `$clog2(TimeoutCycles)`, and it never wraps.

## Structure
- Package `ramio_arbiter_pkg`:
  - state enum `arb_state_e {IDLE, GNT0, GNT1}`.
  - completion-test function (inputs: busy, ready, read_type).
- No sub-module; datapath muxing and the FSM live in one module. Instantiated between the core and `ramio` in the top level.

## Test plan
- Single request to requester 0: read word at 0x100; `ramio` model gives busy for 3 cycles, then ready with 0xDEADBEEF → `m0_done` pulses once in grant cycle 4 with `m0_data_out` = 0xDEADBEEF; `r_*` all 0 the next cycle.
- Both requesters request in the same cycle from reset → requester 0 granted first; requester 1 granted two cycles after requester 0's `done`. Repeat 4 times → grants alternate 0,1,0,1.
- Requester 1 does `sb` of 0x41 to UART out (TopAddress-1) while requester 0 is idle → `r_address` = TopAddress-1 for exactly 1 cycle; `m1_done` in that cycle; UART model receives 0x41 once.
- Requester 0 holds a read while requester 1 keeps requesting for 10 cycles; model holds busy 10 cycles → `r_address` stays `m0_address` throughout and requester 1 is not granted until after requester 0's `done`.
- `TimeoutCycles` = 8, busy stuck at 1 → `m0_done` after 8 granted cycles with data 0; `timeout_err` = 1 and stays 1. A next request still completes normally.
- Assert `rst_n` = 0 in the middle of a grant → next cycle IDLE, no `done`, all outputs 0, and `timeout_err` cleared.
